// File: rtl/operand_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// operand_fetch : register-file write decode and operand-pair fetch, rev 1.0
// ---------------------------------------------------------------------------
module operand_fetch (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] r0,
   input  logic [15:0] r1,
   input  logic [15:0] r2,
   input  logic [15:0] r3,
   input  logic [15:0] r4,
   input  logic [15:0] r5,
   input  logic [15:0] r6,
   input  logic [15:0] r7,
   input  logic [15:0] r8,
   input  logic [15:0] r9,
   input  logic [15:0] r10,
   input  logic [15:0] r11,
   input  logic [15:0] r12,
   input  logic [15:0] r13,
   input  logic [15:0] r14,
   input  logic [15:0] r15,
   input  logic [15:0] ALUBus,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   output logic [15:0] regEnable,
   input  logic        rd_req,
   input  logic [3:0]  rA_addr,
   input  logic [3:0]  rB_addr,
   output logic        rd_ready,
   output logic [15:0] A_out,
   output logic [15:0] B_out,
   output logic        op_valid,
   input  logic        op_ack,
   output logic [7:0]  rd_count
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t      state_q;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [7:0]  cnt_q;
   logic [15:0] a_d;
   logic [15:0] b_d;
   logic [15:0] regs [16];
   logic        accept;

   always_comb begin
      regs[0]  = r0;   regs[1]  = r1;   regs[2]  = r2;   regs[3]  = r3;
      regs[4]  = r4;   regs[5]  = r5;   regs[6]  = r6;   regs[7]  = r7;
      regs[8]  = r8;   regs[9]  = r9;   regs[10] = r10;  regs[11] = r11;
      regs[12] = r12;  regs[13] = r13;  regs[14] = r14;  regs[15] = r15;
   end

   assign regEnable = (wr_en && !reset) ? (16'h0001 << wr_addr) : 16'h0000;

   assign rd_ready = !reset && ((state_q == IDLE) || op_ack);
   assign accept   = rd_req && rd_ready;

   // Same-cycle write to a source register is forwarded from ALUBus.
   assign a_d = (wr_en && (wr_addr == rA_addr)) ? ALUBus : regs[rA_addr];
   assign b_d = (wr_en && (wr_addr == rB_addr)) ? ALUBus : regs[rB_addr];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= 16'h0000;
         b_q     <= 16'h0000;
         cnt_q   <= 8'h00;
      end else if (accept) begin
         state_q <= HOLD;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_q + 8'd1;
      end else if ((state_q == HOLD) && op_ack) begin
         state_q <= IDLE;
      end
   end

   assign A_out    = a_q;
   assign B_out    = b_q;
   assign op_valid = (state_q == HOLD);
   assign rd_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_operand_fetch : self-checking scoreboard bench for operand_fetch, rev 1.0
// ---------------------------------------------------------------------------
module tb_operand_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] rf [16];
   logic [15:0] ALUBus;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] regEnable;
   logic        rd_req;
   logic [3:0]  rA_addr;
   logic [3:0]  rB_addr;
   logic        rd_ready;
   logic [15:0] A_out;
   logic [15:0] B_out;
   logic        op_valid;
   logic        op_ack;
   logic [7:0]  rd_count;

   int          n_tests = 0;
   int          n_fail  = 0;

   // reference model state
   logic [31:0] sb [$];
   logic        st_m;
   logic [7:0]  cnt_m;
   logic [15:0] hold_a;
   logic [15:0] hold_b;

   always #5 clk = ~clk;

   operand_fetch dut (
      .clk      (clk),
      .reset    (reset),
      .r0       (rf[0]),  .r1  (rf[1]),  .r2  (rf[2]),  .r3  (rf[3]),
      .r4       (rf[4]),  .r5  (rf[5]),  .r6  (rf[6]),  .r7  (rf[7]),
      .r8       (rf[8]),  .r9  (rf[9]),  .r10 (rf[10]), .r11 (rf[11]),
      .r12      (rf[12]), .r13 (rf[13]), .r14 (rf[14]), .r15 (rf[15]),
      .ALUBus   (ALUBus),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .regEnable(regEnable),
      .rd_req   (rd_req),
      .rA_addr  (rA_addr),
      .rB_addr  (rB_addr),
      .rd_ready (rd_ready),
      .A_out    (A_out),
      .B_out    (B_out),
      .op_valid (op_valid),
      .op_ack   (op_ack),
      .rd_count (rd_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock: check combinational outputs, predict, clock, then compare.
   task automatic cycle();
      logic        exp_ready;
      logic [15:0] exp_en;
      logic        acc;
      logic [15:0] ea, eb;
      logic [31:0] pair;
      #1;
      exp_ready = !reset && (!st_m || op_ack);
      exp_en    = (wr_en && !reset) ? (16'h0001 << wr_addr) : 16'h0000;
      check("rd_ready", {31'b0, rd_ready}, {31'b0, exp_ready});
      check("regEnable", {16'b0, regEnable}, {16'b0, exp_en});
      acc = rd_req && exp_ready;
      if (acc) begin
         ea = (wr_en && wr_addr == rA_addr) ? ALUBus : rf[rA_addr];
         eb = (wr_en && wr_addr == rB_addr) ? ALUBus : rf[rB_addr];
         sb.push_back({ea, eb});
      end
      if (reset) begin
         st_m = 1'b0; cnt_m = 8'h00; hold_a = 16'h0; hold_b = 16'h0;
      end else if (acc) begin
         st_m = 1'b1; cnt_m = cnt_m + 8'd1;
      end else if (st_m && op_ack) begin
         st_m = 1'b0;
      end
      @(posedge clk);
      #1;
      if (wr_en && !reset) rf[wr_addr] = ALUBus;
      if (acc && !reset) begin
         if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
         end else begin
            pair   = sb.pop_front();
            hold_a = pair[31:16];
            hold_b = pair[15:0];
         end
      end
      check("A_out", {16'b0, A_out}, {16'b0, hold_a});
      check("B_out", {16'b0, B_out}, {16'b0, hold_b});
      check("op_valid", {31'b0, op_valid}, {31'b0, st_m});
      check("rd_count", {24'b0, rd_count}, {24'b0, cnt_m});
   endtask

   task automatic drive(input logic rq, input logic [3:0] a, input logic [3:0] b,
                        input logic ack, input logic we, input logic [3:0] wa,
                        input logic [15:0] bus);
      rd_req = rq; rA_addr = a; rB_addr = b; op_ack = ack;
      wr_en = we; wr_addr = wa; ALUBus = bus;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);
      st_m = 1'b0; cnt_m = 8'h00; hold_a = 16'h0; hold_b = 16'h0;
      reset = 1'b1;
      drive(1'b1, 4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 16'h5555);
      cycle();
      cycle();
      check("reset_rd_ready", {31'b0, rd_ready}, 32'd0);
      reset = 1'b0;

      // decode only, no read
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 4'd5, 16'h0055);
      #1;
      check("decode_5", {16'b0, regEnable}, 32'h0000_0020);
      cycle();
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd5, 16'h0055);
      #1;
      check("decode_off", {16'b0, regEnable}, 32'h0);
      cycle();

      // basic read
      rf[3] = 16'h1234; rf[7] = 16'hABCD;
      drive(1'b1, 4'd3, 4'd7, 1'b0, 1'b0, 4'd0, 16'h0);
      cycle();
      check("basic_A", {16'b0, A_out}, 32'h1234);
      check("basic_B", {16'b0, B_out}, 32'hABCD);

      // stall three cycles while r3 is overwritten
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'd3, 4'd3, 1'b0, 1'b1, 4'd3, 16'h9999);
         cycle();
      end
      check("stall_A", {16'b0, A_out}, 32'h1234);
      check("stall_cnt", {24'b0, rd_count}, 32'd1);
      drive(1'b1, 4'd3, 4'd7, 1'b1, 1'b0, 4'd0, 16'h0);
      cycle();
      check("unstall_A", {16'b0, A_out}, 32'h9999);
      drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 16'h0);
      cycle();

      // bypass with identical sources, from IDLE
      rf[2] = 16'h0001;
      drive(1'b1, 4'd2, 4'd2, 1'b0, 1'b1, 4'd2, 16'hBEEF);
      cycle();
      check("bypass_A", {16'b0, A_out}, 32'hBEEF);
      check("bypass_B", {16'b0, B_out}, 32'hBEEF);

      // reset in HOLD
      reset = 1'b1;
      drive(1'b1, 4'd1, 4'd1, 1'b1, 1'b1, 4'd4, 16'h7777);
      cycle();
      check("rst_valid", {31'b0, op_valid}, 32'd0);
      reset = 1'b0;
      drive(1'b1, 4'd1, 4'd4, 1'b0, 1'b0, 4'd0, 16'h0);
      #1;
      check("post_rst_ready", {31'b0, rd_ready}, 32'd1);
      cycle();

      // back-to-back from a clean count
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      for (int i = 0; i < 300; i++) begin
         drive(1'b1, 4'(i), 4'(i + 5), 1'b1, 1'b1, 4'(i * 3), 16'(i * 37));
         cycle();
      end
      check("b2b_count", {24'b0, rd_count}, 32'd44);
      check("b2b_valid", {31'b0, op_valid}, 32'd1);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         drive(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
               1'($urandom), 4'($urandom), 16'($urandom));
         cycle();
      end
      reset = 1'b0;
      drive(1'b0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd0, 16'h0);
      cycle();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
